output_holder: RTL and testbench

Buffers the stream-cipher core's output words until a full block is collected, then holds and presents them to the chip output pins. Sits downstream of the cipher core and beside `interface_fsm`. It drives `output_is_ready` to `interface_fsm` and reads back its `interface_state_out` to decide when to accept, present and clear data.

---
 rtl/output_holder.sv | 83 ++++++++
 tb/tb_output_holder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/output_holder.sv
// output_holder: collects a block of cipher words, then holds and presents them to the pins.
package types_pkg;
    typedef enum logic [1:0] {I_IDLE, I_PROCESSING, I_DONE} interface_state_t;
endpackage

module output_holder
    import types_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  interface_state_t           interface_state,
    input  logic                       cipher_valid,
    input  logic [DATA_W-1:0]          cipher_data,
    output logic                       cipher_ready,
    output logic                       output_is_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    input  logic                       out_next,
    output logic [$clog2(DEPTH+1)-1:0] fill_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    typedef enum logic {H_FILL, H_HOLD} hold_state_t;
    hold_state_t state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic rdy_q, rdy_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic wr;
    assign cipher_ready    = state_q == H_FILL && interface_state == I_PROCESSING;
    assign wr              = cipher_valid && cipher_ready;
    assign out_valid       = state_q == H_HOLD && interface_state == I_DONE;
    assign out_data        = out_valid ? mem[rd_ptr_q] : '0;
    assign out_last        = out_valid && rd_ptr_q == PW'(DEPTH-1);
    assign output_is_ready = rdy_q;
    assign fill_count      = fill_q;
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        rdy_d    = rdy_q;
        if (interface_state == I_IDLE) begin
            state_d  = H_FILL;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            rdy_d    = 1'b0;
        end else if (wr) begin
            wr_ptr_d = wr_ptr_q == PW'(DEPTH-1) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = fill_q + 1'b1;
            if (fill_q == CW'(DEPTH-1)) begin
                state_d = H_HOLD;
                rdy_d   = 1'b1;
            end
        end else if (out_next && out_valid) begin
            rd_ptr_d = rd_ptr_q == PW'(DEPTH-1) ? '0 : rd_ptr_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= H_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            rdy_q    <= rdy_d;
        end
    end
    // storage survives reset; only the pointers forget it
    always_ff @(posedge clk) begin
        if (!rst && wr) mem[wr_ptr_q] <= cipher_data;
    end
endmodule

// File: tb/tb_output_holder.sv
// tb_output_holder: directed checks of fill, gated readout, wrap, clear and reset.
module tb_output_holder;
    import types_pkg::*;
    logic clk = 1'b0;
    logic rst, cipher_valid, cipher_ready, output_is_ready, out_valid, out_last, out_next;
    logic [7:0] cipher_data, out_data;
    logic [2:0] fill_count;
    interface_state_t interface_state;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] blk_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] blk_b [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};

    output_holder #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .interface_state(interface_state),
        .cipher_valid(cipher_valid), .cipher_data(cipher_data), .cipher_ready(cipher_ready),
        .output_is_ready(output_is_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_next(out_next), .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; interface_state = I_IDLE; cipher_valid = 1'b0; cipher_data = '0; out_next = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_fill", 32'(fill_count), 0);
        chk("rst_oir", 32'(output_is_ready), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_cready", 32'(cipher_ready), 0);
        // back-to-back fill of block A
        interface_state = I_PROCESSING;
        #1 chk("proc_cready", 32'(cipher_ready), 1);
        for (int i = 0; i < 4; i++) begin
            cipher_valid = 1'b1; cipher_data = blk_a[i];
            tick();
            chk("fill_a", 32'(fill_count), 32'(i + 1));
        end
        chk("oir_a", 32'(output_is_ready), 1);
        chk("hold_cready", 32'(cipher_ready), 0);
        // offered word while holding must be ignored
        cipher_data = 8'h55;
        tick();
        cipher_valid = 1'b0;
        chk("hold_fill", 32'(fill_count), 4);
        // out_next while still processing is gated off
        out_next = 1'b1;
        #1 chk("gate_valid", 32'(out_valid), 0);
        chk("gate_data", 32'(out_data), 0);
        tick();
        out_next = 1'b0;
        interface_state = I_DONE;
        #1 chk("done_valid", 32'(out_valid), 1);
        for (int k = 0; k < 4; k++) begin
            chk("read_a", 32'(out_data), 32'(blk_a[k]));
            chk("last_a", 32'(out_last), 32'(k == 3));
            out_next = 1'b1;
            tick();
            out_next = 1'b0;
        end
        chk("wrap_a", 32'(out_data), 32'h11);
        out_next = 1'b1;
        tick();
        chk("held_1", 32'(out_data), 32'h22);
        tick();
        chk("held_2", 32'(out_data), 32'h33);
        // clear wins over a simultaneous advance
        interface_state = I_IDLE;
        tick();
        out_next = 1'b0;
        chk("clr_fill", 32'(fill_count), 0);
        chk("clr_oir", 32'(output_is_ready), 0);
        chk("clr_valid", 32'(out_valid), 0);
        // partial fill kept while not processing, then reset mid-fill
        interface_state = I_PROCESSING;
        for (int i = 0; i < 2; i++) begin
            cipher_valid = 1'b1; cipher_data = 8'hA0 + 8'(i);
            tick();
        end
        cipher_valid = 1'b0;
        interface_state = I_DONE;
        tick();
        chk("part_fill", 32'(fill_count), 2);
        chk("part_valid", 32'(out_valid), 0);
        interface_state = I_PROCESSING;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_fill", 32'(fill_count), 0);
        for (int i = 0; i < 4; i++) begin
            cipher_valid = 1'b1; cipher_data = blk_b[i];
            tick();
        end
        cipher_valid = 1'b0;
        chk("fill_b", 32'(fill_count), 4);
        chk("oir_b", 32'(output_is_ready), 1);
        interface_state = I_DONE;
        #1 chk("read_b0", 32'(out_data), 32'hB1);
        out_next = 1'b1;
        tick();
        out_next = 1'b0;
        chk("read_b1", 32'(out_data), 32'hB2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
